usb_stream_fifo_writer: RTL and testbench
=========================================

// Module: usb_stream_fifo_writer
// PURPOSE
//   Consumer end of the multiplexed test-data stream (OutTestData/OutTestDataEnable/ExternalFifoFull).
//   Buffers 16-bit words from the active mode (acquisition, S-curve, ADC) and writes them to the
//   external USB slave FIFO. Drives back-pressure to the producer and closes short packets (PKTEND) on run stop.
// PARAMETERS
//   DEPTH          512  internal FIFO depth in words, power of 2
//   AF_MARGIN      16   almost-full margin; back-pressure asserts when level >= DEPTH-AF_MARGIN
//   PACKET_WORDS   256  USB packet size in 16-bit words (512 B)
// PORTS
//   Clk                 in   1   system clock; all logic on rising edge
//   reset_n             in   1   asynchronous active-low reset
//   InTestData          in   16  data word from the mode switcher
//   InTestDataEnable    in   1   1-cycle strobe; InTestData valid
//   InUsbStartStop      in   1   run level from the mode switcher; 1 = run
//   OutExternalFifoFull out  1   registered almost-full back-pressure to the producer
//   UsbFifoData         out  16  registered data to the USB slave FIFO
//   UsbSlwr_n           out  1   write strobe, active low, 1 cycle per word
//   UsbPktEnd_n         out  1   packet-end strobe, active low, 1 cycle
//   UsbFifoFull_n       in   1   USB FIFO full flag, active low (0 = full); already synchronous to Clk
//   WordCount           out  32  words written to USB in the current run
//   OverflowError       out  1   sticky; a word was dropped because the internal FIFO was full
//   Idle                out  1   1 when the state machine is in IDLE
// BEHAVIOUR
//   Reset values: UsbFifoData=0, UsbSlwr_n=1, UsbPktEnd_n=1, OutExternalFifoFull=0, WordCount=0,
//     OverflowError=0, Idle=1. FIFO empty, packet counter 0, state IDLE.
//   States: IDLE, WRITE, FLUSH, PKTEND.
//   IDLE->WRITE when InUsbStartStop==1. On that transition, clear WordCount, the packet counter
//     and OverflowError.
//   WRITE->FLUSH when InUsbStartStop==0.
//   FLUSH->PKTEND when FIFO empty, no write in flight and packet counter!=0.
//   FLUSH->IDLE when FIFO empty, no write in flight and packet counter==0.
//   PKTEND: assert UsbPktEnd_n=0 for exactly 1 cycle, on the first cycle UsbFifoFull_n==1;
//     then clear the packet counter and go to IDLE.
//   A high InUsbStartStop during FLUSH/PKTEND does not abort the flush; the run restarts from IDLE
//     afterwards.
//   Push: accepted only in WRITE or FLUSH when InTestDataEnable==1; ignored in IDLE and PKTEND.
//     - Push while full with no pop in the same cycle: word dropped, OverflowError set.
//     - Push while full with a simultaneous pop: accepted.
//   Pop: in WRITE or FLUSH, when FIFO not empty and UsbFifoFull_n==1.
//     - Next cycle: UsbFifoData=word, UsbSlwr_n=0, WordCount+1, packet counter+1.
//     - Packet counter wraps PACKET_WORDS-1 -> 0. WordCount wraps at 2^32.
//     - Latency: one cycle from pop to strobe. Max throughput: 1 word/cycle.
//   UsbFifoFull_n==0 stalls pops; data is held and no words are lost.
//   UsbFifoData holds the last written word while UsbSlwr_n=1.
//   OutExternalFifoFull is registered from the level after the current push/pop; it deasserts as
//     soon as level < DEPTH-AF_MARGIN.
//   Reset mid-run: everything returns to reset values immediately (async); buffered data is discarded.
// STRUCTURE
//   Shared package:
//     - state encoding localparams (IDLE, WRITE, FLUSH, PKTEND)
//     - USB_ACTIVE=1'b0 strobe polarity constant
//     - PACKET_WORDS default
//   Sub-module usb_stream_fifo: synchronous FIFO with DEPTH/AF_MARGIN parameters, outputs
//     empty/full/almost_full/level, simultaneous push+pop when full allowed.
//   Top: FSM, counters, output registers.
// TESTING
//   1 Run=1, 300 words 0x0000..0x012B, UsbFifoFull_n=1, run=0
//     -> 300 Slwr_n pulses in order; one PktEnd_n after word 300; WordCount=300.
//   2 Run=1, 512 words, run=0
//     -> 512 writes; no PktEnd_n pulse (counter==0); Idle=1.
//   3 UsbFifoFull_n=0 for 100 cycles while pushing 1 word/cycle
//     -> OutExternalFifoFull=1 at level 496; no Slwr_n pulse while the flag is 0; all words
//        delivered once the flag returns to 1.
//   4 Producer ignores back-pressure: 520 pushes while USB is stalled
//     -> OverflowError=1; 512 words delivered; OverflowError clears on the next run start.
//   5 Run drops and rises again within 2 cycles with 10 words buffered
//     -> 10 words flushed; PktEnd_n asserted; WordCount cleared only at the new IDLE->WRITE.
//   6 reset_n=0 mid-transfer
//     -> same-cycle Slwr_n=1, PktEnd_n=1, Idle=1; FIFO empty after release.

Source files
------------

// File: rtl/usb_stream_fifo_writer_pkg.sv
// Shared constants for the USB stream FIFO writer: FSM encoding, strobe polarity
// and the default USB packet size.
package usb_stream_fifo_writer_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WRITE  = 2'd1;
  localparam logic [1:0] ST_FLUSH  = 2'd2;
  localparam logic [1:0] ST_PKTEND = 2'd3;

  localparam logic USB_ACTIVE   = 1'b0;
  localparam logic USB_INACTIVE = 1'b1;

  localparam int PACKET_WORDS_DEFAULT = 256;

  // Words may enter and leave the buffer only while a run is streaming or draining.
  function automatic logic is_xfer_state(input logic [1:0] state);
    return (state == ST_WRITE) || (state == ST_FLUSH);
  endfunction

endpackage

// File: rtl/usb_stream_fifo_writer_fifo.sv
// Synchronous show-ahead FIFO. A push into a full FIFO is accepted when a pop
// happens in the same cycle; almost_full is registered from the post-update level.
module usb_stream_fifo #(
  parameter int DEPTH     = 512,
  parameter int AF_MARGIN = 16,
  parameter int WIDTH     = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       empty,
  output logic                       full,
  output logic                       almost_full,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [LW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             almost_full_q, almost_full_d;
  logic             do_push, do_pop;
  logic [LW-1:0]    level_next;

  assign level       = wr_ptr_q - rd_ptr_q;
  assign empty       = (level == '0);
  assign full        = (level == LW'(DEPTH));
  assign almost_full = almost_full_q;
  assign pop_data    = mem[rd_ptr_q[AW-1:0]];

  // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    do_pop        = pop && !empty;
    do_push       = push && (!full || do_pop);
    wr_ptr_d      = wr_ptr_q + LW'(do_push);
    rd_ptr_d      = rd_ptr_q + LW'(do_pop);
    level_next    = level + LW'(do_push) - LW'(do_pop);
    almost_full_d = (level_next >= LW'(DEPTH - AF_MARGIN));
  end

  // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      almost_full_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      almost_full_q <= almost_full_d;
    end
  end

  // NOTE: storage is deliberately not reset; resetting the pointers alone empties the FIFO.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/usb_stream_fifo_writer.sv
// Consumer end of the test-data stream: buffers 16-bit words and writes them to the
// external USB slave FIFO, closing short packets with PKTEND when a run stops.
module usb_stream_fifo_writer
  import usb_stream_fifo_writer_pkg::*;
#(
  parameter int DEPTH        = 512,
  parameter int AF_MARGIN    = 16,
  parameter int PACKET_WORDS = PACKET_WORDS_DEFAULT
) (
  input  logic        Clk,
  input  logic        reset_n,
  input  logic [15:0] InTestData,
  input  logic        InTestDataEnable,
  input  logic        InUsbStartStop,
  output logic        OutExternalFifoFull,
  output logic [15:0] UsbFifoData,
  output logic        UsbSlwr_n,
  output logic        UsbPktEnd_n,
  input  logic        UsbFifoFull_n,
  output logic [31:0] WordCount,
  output logic        OverflowError,
  output logic        Idle
);

  localparam int PCW = (PACKET_WORDS > 1) ? $clog2(PACKET_WORDS) : 1;

  logic [1:0]     state_q, state_d;
  logic [15:0]    data_q, data_d;
  logic           slwr_n_q, slwr_n_d;
  logic           pktend_n_q, pktend_n_d;
  logic [31:0]    word_count_q, word_count_d;
  logic [PCW-1:0] pkt_cnt_q, pkt_cnt_d;
  logic           overflow_q, overflow_d;

  logic                 xfer, push, pop_req, do_pop;
  logic [15:0]          fifo_rd_data;
  logic                 fifo_empty, fifo_full, fifo_af;
  logic [$clog2(DEPTH):0] fifo_level;

  assign xfer    = is_xfer_state(state_q);
  assign push    = xfer && InTestDataEnable;
  assign pop_req = xfer && UsbFifoFull_n;
  assign do_pop  = pop_req && !fifo_empty;

  usb_stream_fifo #(
    .DEPTH     (DEPTH),
    .AF_MARGIN (AF_MARGIN),
    .WIDTH     (16)
  ) u_fifo (
    .clk         (Clk),
    .rst_n       (reset_n),
    .push        (push),
    .push_data   (InTestData),
    .pop         (pop_req),
    .pop_data    (fifo_rd_data),
    .empty       (fifo_empty),
    .full        (fifo_full),
    .almost_full (fifo_af),
    .level       (fifo_level)
  );

  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    slwr_n_d     = USB_INACTIVE;
    pktend_n_d   = USB_INACTIVE;
    word_count_d = word_count_q;
    pkt_cnt_d    = pkt_cnt_q;
    overflow_d   = overflow_q;

    if (do_pop) begin
      data_d       = fifo_rd_data;
      slwr_n_d     = USB_ACTIVE;
      word_count_d = word_count_q + 32'd1;
      pkt_cnt_d    = (pkt_cnt_q == PCW'(PACKET_WORDS - 1)) ? '0 : pkt_cnt_q + PCW'(1);
    end

    if (push && fifo_full && !do_pop) overflow_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (InUsbStartStop) begin
          state_d      = ST_WRITE;
          word_count_d = '0;
          pkt_cnt_d    = '0;
          overflow_d   = 1'b0;
        end
      end
      ST_WRITE: begin
        if (!InUsbStartStop) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        // The last strobe must retire first so its packet count is final.
        if (fifo_empty && (slwr_n_q == USB_INACTIVE))
          state_d = (pkt_cnt_q != '0) ? ST_PKTEND : ST_IDLE;
      end
      ST_PKTEND: begin
        if (UsbFifoFull_n) begin
          pktend_n_d = USB_ACTIVE;
          pkt_cnt_d  = '0;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      data_q       <= '0;
      slwr_n_q     <= USB_INACTIVE;
      pktend_n_q   <= USB_INACTIVE;
      word_count_q <= '0;
      pkt_cnt_q    <= '0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      slwr_n_q     <= slwr_n_d;
      pktend_n_q   <= pktend_n_d;
      word_count_q <= word_count_d;
      pkt_cnt_q    <= pkt_cnt_d;
      overflow_q   <= overflow_d;
    end
  end

  assign UsbFifoData         = data_q;
  assign UsbSlwr_n           = slwr_n_q;
  assign UsbPktEnd_n         = pktend_n_q;
  assign WordCount           = word_count_q;
  assign OverflowError       = overflow_q;
  assign OutExternalFifoFull = fifo_af;
  assign Idle                = (state_q == ST_IDLE);

endmodule

// File: tb/tb_usb_stream_fifo_writer.sv
// Directed bench for usb_stream_fifo_writer: a negedge monitor collects every USB
// write and packet end, and each scenario compares against hand-derived values.
module tb_usb_stream_fifo_writer;

  logic        Clk = 1'b0;
  logic        reset_n;
  logic [15:0] InTestData;
  logic        InTestDataEnable;
  logic        InUsbStartStop;
  logic        OutExternalFifoFull;
  logic [15:0] UsbFifoData;
  logic        UsbSlwr_n;
  logic        UsbPktEnd_n;
  logic        UsbFifoFull_n;
  logic [31:0] WordCount;
  logic        OverflowError;
  logic        Idle;

  int vectors     = 0;
  int miscompares = 0;

  logic [15:0] got_q[$];
  int          pktend_cnt  = 0;
  int          pkt_at      = -1;
  logic [31:0] wc_at_pkt   = '0;
  int          stall_viol  = 0;
  logic        flag_prev   = 1'b1;

  usb_stream_fifo_writer dut (
    .Clk                 (Clk),
    .reset_n             (reset_n),
    .InTestData          (InTestData),
    .InTestDataEnable    (InTestDataEnable),
    .InUsbStartStop      (InUsbStartStop),
    .OutExternalFifoFull (OutExternalFifoFull),
    .UsbFifoData         (UsbFifoData),
    .UsbSlwr_n           (UsbSlwr_n),
    .UsbPktEnd_n         (UsbPktEnd_n),
    .UsbFifoFull_n       (UsbFifoFull_n),
    .WordCount           (WordCount),
    .OverflowError       (OverflowError),
    .Idle                (Idle)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) flag_prev <= UsbFifoFull_n;

  always @(negedge Clk) begin
    if (reset_n) begin
      if (UsbSlwr_n == 1'b0) begin
        got_q.push_back(UsbFifoData);
        if (flag_prev == 1'b0) stall_viol++;
      end
      if (UsbPktEnd_n == 1'b0) begin
        pktend_cnt++;
        pkt_at    = got_q.size();
        wc_at_pkt = WordCount;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_sb();
    got_q.delete();
    pktend_cnt = 0;
    pkt_at     = -1;
    wc_at_pkt  = '0;
    stall_viol = 0;
  endtask

  task automatic push_burst(input int n, input logic [15:0] base);
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      InTestDataEnable = 1'b1;
      InTestData       = base + 16'(i);
    end
    @(negedge Clk);
    InTestDataEnable = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    repeat (2) @(negedge Clk);
    while (Idle !== 1'b1 && n < budget) begin
      @(negedge Clk);
      n++;
    end
    check({tag, "_idle_reached"}, 32'(Idle), 32'd1);
    repeat (3) @(negedge Clk);
  endtask

  task automatic verify_words(input string tag, input int n, input logic [15:0] base);
    int errs = 0;
    check({tag, "_word_count_seen"}, 32'(got_q.size()), 32'(n));
    for (int i = 0; i < n && i < got_q.size(); i++)
      if (got_q[i] !== base + 16'(i)) errs++;
    check({tag, "_word_order_errs"}, 32'(errs), 32'd0);
  endtask

  initial begin
    reset_n          = 1'b0;
    InTestData       = '0;
    InTestDataEnable = 1'b0;
    InUsbStartStop   = 1'b0;
    UsbFifoFull_n    = 1'b1;
    repeat (3) @(negedge Clk);

    check("rst_data",     32'(UsbFifoData),         32'h0);
    check("rst_slwr",     32'(UsbSlwr_n),           32'd1);
    check("rst_pktend",   32'(UsbPktEnd_n),         32'd1);
    check("rst_extfull",  32'(OutExternalFifoFull), 32'd0);
    check("rst_wordcnt",  WordCount,                32'd0);
    check("rst_overflow", 32'(OverflowError),       32'd0);
    check("rst_idle",     32'(Idle),                32'd1);
    reset_n = 1'b1;
    @(negedge Clk);

    // 1: 300 words, short final packet closed by PKTEND after word 300
    clear_sb();
    InUsbStartStop = 1'b1;
    push_burst(300, 16'h0000);
    InUsbStartStop = 1'b0;
    wait_idle("t1", 1000);
    verify_words("t1", 300, 16'h0000);
    check("t1_pktend_cnt", 32'(pktend_cnt), 32'd1);
    check("t1_pktend_pos", 32'(pkt_at),     32'd300);
    check("t1_wordcount",  WordCount,       32'd300);

    // 2: 512 words is exactly two packets, so no PKTEND
    clear_sb();
    InUsbStartStop = 1'b1;
    push_burst(512, 16'h1000);
    InUsbStartStop = 1'b0;
    wait_idle("t2", 1000);
    verify_words("t2", 512, 16'h1000);
    check("t2_pktend_cnt", 32'(pktend_cnt), 32'd0);
    check("t2_wordcount",  WordCount,       32'd512);
    check("t2_idle",       32'(Idle),       32'd1);

    // 3: USB stalled; almost-full asserts exactly at level 496
    clear_sb();
    UsbFifoFull_n  = 1'b0;
    InUsbStartStop = 1'b1;
    push_burst(495, 16'h2000);
    check("t3_af_at_495", 32'(OutExternalFifoFull), 32'd0);
    push_burst(1, 16'h2000 + 16'd495);
    check("t3_af_at_496", 32'(OutExternalFifoFull), 32'd1);
    repeat (100) @(negedge Clk);
    check("t3_no_write_stalled", 32'(got_q.size()), 32'd0);
    UsbFifoFull_n = 1'b1;
    @(negedge Clk);
    check("t3_af_release", 32'(OutExternalFifoFull), 32'd0);
    InUsbStartStop = 1'b0;
    wait_idle("t3", 2000);
    verify_words("t3", 496, 16'h2000);
    check("t3_stall_viol",  32'(stall_viol), 32'd0);
    check("t3_wordcount",   WordCount,       32'd496);
    check("t3_pktend_cnt",  32'(pktend_cnt), 32'd1);

    // 4: 520 pushes into a stalled 512-deep buffer
    clear_sb();
    UsbFifoFull_n  = 1'b0;
    InUsbStartStop = 1'b1;
    push_burst(520, 16'h4000);
    check("t4_overflow_set", 32'(OverflowError), 32'd1);
    UsbFifoFull_n  = 1'b1;
    InUsbStartStop = 1'b0;
    wait_idle("t4", 2000);
    verify_words("t4", 512, 16'h4000);
    check("t4_overflow_sticky", 32'(OverflowError), 32'd1);
    check("t4_pktend_cnt",      32'(pktend_cnt),    32'd0);
    InUsbStartStop = 1'b1;
    repeat (2) @(negedge Clk);
    check("t4_overflow_clear", 32'(OverflowError), 32'd0);
    check("t4_wc_clear",       WordCount,          32'd0);
    InUsbStartStop = 1'b0;
    wait_idle("t4b", 100);

    // 5: run glitches low for one cycle with 10 words buffered
    clear_sb();
    UsbFifoFull_n  = 1'b0;
    InUsbStartStop = 1'b1;
    push_burst(10, 16'h5000);
    InUsbStartStop = 1'b0;
    @(negedge Clk);
    InUsbStartStop = 1'b1;
    UsbFifoFull_n  = 1'b1;
    for (int n = 0; n < 200 && pktend_cnt == 0; n++) @(negedge Clk);
    check("t5_pktend_cnt", 32'(pktend_cnt), 32'd1);
    check("t5_wc_at_pkt",  wc_at_pkt,       32'd10);
    repeat (3) @(negedge Clk);
    verify_words("t5", 10, 16'h5000);
    check("t5_wc_restart",  WordCount,  32'd0);
    check("t5_run_again",   32'(Idle),  32'd0);
    InUsbStartStop = 1'b0;
    wait_idle("t5", 100);

    // 6: reset asserted while writes are in progress with data buffered
    clear_sb();
    UsbFifoFull_n  = 1'b0;
    InUsbStartStop = 1'b1;
    push_burst(20, 16'h6000);
    UsbFifoFull_n = 1'b1;
    @(negedge Clk);
    check("t6_pre_slwr", 32'(UsbSlwr_n), 32'd0);
    reset_n = 1'b0;
    #1;
    check("t6_rst_slwr",   32'(UsbSlwr_n),   32'd1);
    check("t6_rst_pktend", 32'(UsbPktEnd_n), 32'd1);
    check("t6_rst_idle",   32'(Idle),        32'd1);
    repeat (2) @(negedge Clk);
    clear_sb();
    reset_n = 1'b1;
    repeat (10) @(negedge Clk);
    check("t6_fifo_empty",  32'(got_q.size()), 32'd0);
    check("t6_wordcount",   WordCount,         32'd0);
    InUsbStartStop = 1'b0;
    wait_idle("t6", 100);
    check("t6_pktend_cnt",  32'(pktend_cnt),   32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
